// File: rtl/mem_port_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported downstream memory interface between
//               the CPU's write port and four read ports. Pending requests
//               are serialised one at a time; each port's completion is held
//               in a served flag so that all ports can report ready in the
//               same cycle and the CPU stall releases once per step.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               write/inaddr/indata      - write-port request, address, data
//               inready                  - write-port completion
//               readN/outaddrN           - read-port requests and addresses
//               outdataN/outreadyN       - read data and read-port completion
//               m_addr/m_read/m_write    - downstream address and strobes
//               m_wdata/m_rdata/m_done   - downstream data and completion
//               busy                     - downstream transaction in flight
//               err                      - sticky downstream timeout flag
// Revision    : 1.0 - initial release
//==============================================================================
module mem_port_arbiter #(
    parameter int AW  = 14,
    parameter int DW  = 10,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rst,
    // write port
    input  logic          write,
    input  logic [AW-1:0] inaddr,
    input  logic [DW-1:0] indata,
    output logic          inready,
    // read ports
    input  logic          read1,
    input  logic          read2,
    input  logic          read3,
    input  logic          read4,
    input  logic [AW-1:0] outaddr1,
    input  logic [AW-1:0] outaddr2,
    input  logic [AW-1:0] outaddr3,
    input  logic [AW-1:0] outaddr4,
    output logic [DW-1:0] outdata1,
    output logic [DW-1:0] outdata2,
    output logic [DW-1:0] outdata3,
    output logic [DW-1:0] outdata4,
    output logic          outready1,
    output logic          outready2,
    output logic          outready3,
    output logic          outready4,
    // downstream memory
    output logic [AW-1:0] m_addr,
    output logic          m_read,
    output logic          m_write,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_done,
    // status
    output logic          busy,
    output logic          err
);

    // Counter wide enough to hold TMO; saturates so a disabled timeout
    // (TMO == 0) never wraps back through a stale compare value.
    localparam int              c_CW       = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic            c_TMO_EN   = (TMO != 0);
    localparam logic [c_CW-1:0] c_CNT_LAST = (TMO == 0) ? '0 : c_CW'(TMO - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX  = '1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    // Grant index: 0 is the write port, 1..4 are read1..read4.
    localparam logic [2:0] c_GNT_WR = 3'd0;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [2:0]      r_gnt;
    logic [AW-1:0]   r_gnt_addr;
    logic [DW-1:0]   r_gnt_data;
    logic [c_CW-1:0] r_cnt;
    logic            r_err;

    logic            r_wr_served;
    logic [AW-1:0]   r_wr_lat_addr;
    logic [DW-1:0]   r_wr_lat_data;

    logic [3:0]      r_rd_served;
    logic [AW-1:0]   r_rd_lat_addr [4];
    logic [DW-1:0]   r_rd_data     [4];

    //--------------------------------------------------------------------------
    // Read-port packing (index 0 is read1)
    //--------------------------------------------------------------------------
    logic [3:0]    w_rd_req;
    logic [AW-1:0] w_rd_addr [4];

    assign w_rd_req     = {read4, read3, read2, read1};
    assign w_rd_addr[0] = outaddr1;
    assign w_rd_addr[1] = outaddr2;
    assign w_rd_addr[2] = outaddr3;
    assign w_rd_addr[3] = outaddr4;

    //--------------------------------------------------------------------------
    // Ready and pending terms. A port is ready only while its live request
    // still matches what was served, so a changed request is re-fetched.
    //--------------------------------------------------------------------------
    logic       w_wr_ready;
    logic [3:0] w_rd_ready;
    logic       w_wr_pend;
    logic [3:0] w_rd_pend;

    assign w_wr_ready = r_wr_served & write & (inaddr == r_wr_lat_addr)
                        & (indata == r_wr_lat_data);

    generate
        for (genvar i = 0; i < 4; i++) begin : g_rd_ready
            assign w_rd_ready[i] = r_rd_served[i] & w_rd_req[i]
                                   & (w_rd_addr[i] == r_rd_lat_addr[i]);
        end
    endgenerate

    assign w_wr_pend = write & ~w_wr_ready;
    assign w_rd_pend = w_rd_req & ~w_rd_ready;

    //--------------------------------------------------------------------------
    // Fixed-priority selection: write, read1, read2, read3, read4
    //--------------------------------------------------------------------------
    logic          w_any_pend;
    logic [2:0]    w_sel;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;

    always_comb begin
        w_any_pend = 1'b1;
        w_sel      = c_GNT_WR;
        w_sel_addr = inaddr;
        w_sel_data = indata;
        if (w_wr_pend) begin
            w_sel      = c_GNT_WR;
            w_sel_addr = inaddr;
            w_sel_data = indata;
        end else if (w_rd_pend[0]) begin
            w_sel      = 3'd1;
            w_sel_addr = outaddr1;
            w_sel_data = '0;
        end else if (w_rd_pend[1]) begin
            w_sel      = 3'd2;
            w_sel_addr = outaddr2;
            w_sel_data = '0;
        end else if (w_rd_pend[2]) begin
            w_sel      = 3'd3;
            w_sel_addr = outaddr3;
            w_sel_data = '0;
        end else if (w_rd_pend[3]) begin
            w_sel      = 3'd4;
            w_sel_addr = outaddr4;
            w_sel_data = '0;
        end else begin
            w_any_pend = 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Transaction completion. m_done wins over a simultaneous timeout.
    //--------------------------------------------------------------------------
    logic w_is_busy;
    logic w_done;
    logic w_tmo;
    logic w_finish;
    logic w_gnt_wr;

    assign w_is_busy = (r_state == S_BUSY);
    assign w_done    = w_is_busy & m_done;
    assign w_tmo     = w_is_busy & ~m_done & c_TMO_EN & (r_cnt == c_CNT_LAST);
    assign w_finish  = w_done | w_tmo;
    assign w_gnt_wr  = (r_gnt == c_GNT_WR);

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_pend) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_finish) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Grant latch, timeout counter, sticky error
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt      <= c_GNT_WR;
            r_gnt_addr <= '0;
            r_gnt_data <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_any_pend) begin
                r_gnt      <= w_sel;
                r_gnt_addr <= w_sel_addr;
                r_gnt_data <= w_sel_data;
            end
            if (!w_is_busy) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Write-port completion state
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_served   <= 1'b0;
            r_wr_lat_addr <= '0;
            r_wr_lat_data <= '0;
        end else if (w_finish && w_gnt_wr) begin
            r_wr_served   <= 1'b1;
            r_wr_lat_addr <= r_gnt_addr;
            r_wr_lat_data <= r_gnt_data;
        end else if (r_wr_served && !w_wr_ready) begin
            r_wr_served <= 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Read-port completion state. A completing write to an address a read
    // port holds invalidates that port so it fetches the new value.
    //--------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 4; i++) begin : g_rd_port
            localparam logic [2:0] c_IDX = 3'(i + 1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_served[i]   <= 1'b0;
                    r_rd_lat_addr[i] <= '0;
                    r_rd_data[i]     <= '0;
                end else if (w_finish && (r_gnt == c_IDX)) begin
                    r_rd_served[i]   <= 1'b1;
                    r_rd_lat_addr[i] <= r_gnt_addr;
                    r_rd_data[i]     <= w_done ? m_rdata : '0;
                end else if (w_finish && w_gnt_wr && r_rd_served[i]
                             && (r_rd_lat_addr[i] == r_gnt_addr)) begin
                    r_rd_served[i] <= 1'b0;
                end else if (r_rd_served[i] && !w_rd_ready[i]) begin
                    r_rd_served[i] <= 1'b0;
                end
            end
        end
    endgenerate

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign inready   = w_wr_ready;
    assign outready1 = w_rd_ready[0];
    assign outready2 = w_rd_ready[1];
    assign outready3 = w_rd_ready[2];
    assign outready4 = w_rd_ready[3];
    assign outdata1  = r_rd_data[0];
    assign outdata2  = r_rd_data[1];
    assign outdata3  = r_rd_data[2];
    assign outdata4  = r_rd_data[3];

    assign m_addr  = r_gnt_addr;
    assign m_wdata = r_gnt_data;
    assign m_read  = w_is_busy & ~w_gnt_wr;
    assign m_write = w_is_busy & w_gnt_wr;
    assign busy    = w_is_busy;
    assign err     = r_err;

endmodule
`default_nettype wire
